// File: rtl/equihash_pkg.sv
// equihash_pkg: Zcash block header layout and serializer state encoding.
package equihash_pkg;
  // Fields listed MSB-first so header byte 0 (version LSB) lands in bits [7:0].
  typedef struct packed {
    logic [1344*8-1:0] equihash_sol;
    logic [23:0]       sol_size;
    logic [255:0]      nonce;
    logic [31:0]       bits;
    logic [31:0]       n_time;
    logic [255:0]      reserved;
    logic [255:0]      merkle_root;
    logic [255:0]      hash_prev_block;
    logic [31:0]       version;
  } cblockheader_sol_t;
  localparam int HEADER_BYTS = $bits(cblockheader_sol_t) / 8;
  typedef enum logic {IDLE, SEND} ser_state_t;
endpackage

// File: rtl/if_axi_stream.sv
// if_axi_stream: byte-oriented streaming bus with framing, byte-count and control side bands.
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
);
  localparam int MOD_W = DAT_BYTS > 1 ? $clog2(DAT_BYTS) : 1;
  logic [DAT_BYTS*8-1:0] dat;
  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [MOD_W-1:0]      mod;
  logic [CTL_BITS-1:0]   ctl;
  modport source(output dat, val, sop, eop, err, mod, ctl, input rdy);
  modport sink(input dat, val, sop, eop, err, mod, ctl, output rdy);
endinterface

// File: rtl/equihash_header_serializer.sv
// equihash_header_serializer: captures a full header and streams it out DAT_BYTS bytes per beat.
module equihash_header_serializer
  import equihash_pkg::*;
#(
  parameter int DAT_BYTS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  cblockheader_sol_t i_hdr,
  input  logic              i_hdr_val,
  output logic              o_hdr_rdy,
  if_axi_stream.source      o_axi,
  output logic              o_busy
);
  localparam int CNT_W = $clog2(HEADER_BYTS + DAT_BYTS);
  localparam int BEAT_W = DAT_BYTS * 8;
  localparam int MOD_W = DAT_BYTS > 1 ? $clog2(DAT_BYTS) : 1;
  localparam logic [CNT_W-1:0] STEP = CNT_W'(DAT_BYTS);
  localparam logic [CNT_W:0] HB = (CNT_W + 1)'(HEADER_BYTS);
  localparam logic [MOD_W-1:0] LAST_MOD = MOD_W'(HEADER_BYTS % DAT_BYTS);
  ser_state_t state, state_nxt;
  logic live;
  logic [CNT_W-1:0] byte_cnt;
  logic [HEADER_BYTS*8-1:0] hdr_q;
  logic send, accept, beat, last;
  assign send = state == SEND;
  assign accept = i_hdr_val && o_hdr_rdy;
  assign beat = send && o_axi.rdy;
  assign last = ({1'b0, byte_cnt} + {1'b0, STEP}) >= HB;
  always_comb begin
    state_nxt = state;
    state_nxt = send ? ((beat && last) ? IDLE : SEND) : (accept ? SEND : IDLE);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      live <= 1'b0;
      byte_cnt <= '0;
    end else begin
      state <= state_nxt;
      live <= 1'b1;
      byte_cnt <= accept ? '0 : (beat ? byte_cnt + STEP : byte_cnt);
    end
  // Shifting in zeros leaves the bytes past the header end cleared on the final beat.
  always_ff @(posedge i_clk)
    if (accept) hdr_q <= i_hdr;
    else if (beat) hdr_q <= hdr_q >> BEAT_W;
  assign o_hdr_rdy = live && !send;
  assign o_busy = send;
  assign o_axi.val = send;
  assign o_axi.sop = send && byte_cnt == '0;
  assign o_axi.eop = send && last;
  assign o_axi.mod = (send && last) ? LAST_MOD : '0;
  assign o_axi.dat = send ? hdr_q[BEAT_W-1:0] : '0;
  assign o_axi.err = 1'b0;
  assign o_axi.ctl = '0;
endmodule

// File: tb/tb_equihash_header_serializer.sv
// tb_equihash_header_serializer: directed checks of header serialization at 8- and 64-byte widths.
module tb_equihash_header_serializer;
  import equihash_pkg::*;
  localparam int NB8 = 186;
  localparam int NB64 = 24;
  logic clk, rst_n, hv8, hv64, hrdy8, hrdy64, busy8, busy64;
  cblockheader_sol_t hdr;
  int checks, passes;
  if_axi_stream #(.DAT_BYTS(8)) a8();
  if_axi_stream #(.DAT_BYTS(64)) a64();
  equihash_header_serializer #(.DAT_BYTS(8)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_hdr(hdr), .i_hdr_val(hv8),
    .o_hdr_rdy(hrdy8), .o_axi(a8), .o_busy(busy8)
  );
  equihash_header_serializer #(.DAT_BYTS(64)) u64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_hdr(hdr), .i_hdr_val(hv64),
    .o_hdr_rdy(hrdy64), .o_axi(a64), .o_busy(busy64)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat_byte(input bit sel, input int idx);
    return idx >= HEADER_BYTS ? 8'h00 : (sel ? 8'(idx * 7 + 3) : 8'(idx));
  endfunction
  function automatic logic [HEADER_BYTS*8-1:0] mk_hdr(input bit sel);
    logic [HEADER_BYTS*8-1:0] h;
    for (int i = 0; i < HEADER_BYTS; i++) h[i*8 +: 8] = pat_byte(sel, i);
    return h;
  endfunction
  function automatic logic [63:0] beat8(input bit sel, input int k);
    logic [63:0] d;
    for (int b = 0; b < 8; b++) d[b*8 +: 8] = pat_byte(sel, k * 8 + b);
    return d;
  endfunction
  function automatic logic [511:0] beat64(input bit sel, input int k);
    logic [511:0] d;
    for (int b = 0; b < 64; b++) d[b*8 +: 8] = pat_byte(sel, k * 64 + b);
    return d;
  endfunction

  task automatic accept8(input bit sel, input bit hold);
    int n;
    hdr = mk_hdr(sel);
    hv8 = 1'b1;
    for (n = 0; n < 20 && !hrdy8; n++) @(negedge clk);
    checks++;
    if (!hrdy8) $display("FAIL accept8 hdr_rdy got=%b exp=1", hrdy8);
    else passes++;
    @(posedge clk);
    #1 hv8 = hold;
  endtask

  task automatic accept64(input bit sel);
    int n;
    hdr = mk_hdr(sel);
    hv64 = 1'b1;
    for (n = 0; n < 20 && !hrdy64; n++) @(negedge clk);
    checks++;
    if (!hrdy64) $display("FAIL accept64 hdr_rdy got=%b exp=1", hrdy64);
    else passes++;
    @(posedge clk);
    #1 hv64 = 1'b0;
  endtask

  task automatic collect8(input bit sel, input bit rnd, input int stop,
                          output logic [63:0] first_dat, output logic [63:0] last_dat);
    int k, cyc;
    bit r;
    logic [70:0] got, exp;
    k = 0;
    cyc = 0;
    first_dat = 'x;
    last_dat = 'x;
    while (k < stop && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      got = {a8.val, hrdy8, busy8, a8.sop, a8.eop, a8.mod, a8.dat};
      exp = {1'b1, 1'b0, 1'b1, k == 0, k == NB8 - 1, (k == NB8 - 1) ? 3'd7 : 3'd0, beat8(sel, k)};
      checks++;
      if (got !== exp) begin
        $display("FAIL beat8 k=%0d got=%h exp=%h", k, got, exp);
        if (!a8.val) return;
      end else passes++;
      if (k == 0) first_dat = a8.dat;
      if (k == NB8 - 1) last_dat = a8.dat;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      a8.rdy = r;
      if (r) k++;
    end
    checks++;
    if (k < stop) $display("FAIL collect8 timeout beats got=%0d exp=%0d", k, stop);
    else passes++;
  endtask

  task automatic collect64(input bit sel, output logic [511:0] last_dat);
    int k, cyc;
    logic [522:0] got, exp;
    k = 0;
    cyc = 0;
    last_dat = 'x;
    a64.rdy = 1'b1;
    while (k < NB64 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      got = {a64.val, hrdy64, busy64, a64.sop, a64.eop, a64.mod, a64.dat};
      exp = {1'b1, 1'b0, 1'b1, k == 0, k == NB64 - 1, (k == NB64 - 1) ? 6'd15 : 6'd0, beat64(sel, k)};
      checks++;
      if (got !== exp) begin
        $display("FAIL beat64 k=%0d got=%h exp=%h", k, got, exp);
        if (!a64.val) return;
      end else passes++;
      if (k == NB64 - 1) last_dat = a64.dat;
      k++;
    end
    checks++;
    if (k < NB64) $display("FAIL collect64 timeout beats got=%0d exp=%0d", k, NB64);
    else passes++;
  endtask

  task automatic check_idle8(input string name, input logic exp_rdy);
    logic [2:0] got;
    @(negedge clk);
    got = {a8.val, hrdy8, busy8};
    checks++;
    if (got !== {1'b0, exp_rdy, 1'b0}) $display("FAIL %s val/rdy/busy got=%b exp=%b", name, got, {1'b0, exp_rdy, 1'b0});
    else passes++;
  endtask

  task automatic test_reset();
    logic [81:0] got;
    #1;
    got = {a8.val, a8.sop, a8.eop, a8.mod, a8.err, a8.ctl, a8.dat, hrdy8, busy8, a64.val, hrdy64};
    checks++;
    if (got !== '0) $display("FAIL reset_state got=%h exp=0", got);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({hrdy8, hrdy64, busy8, busy64} !== 4'b1100) $display("FAIL reset_release got=%b exp=1100", {hrdy8, hrdy64, busy8, busy64});
    else passes++;
  endtask

  task automatic test_basic();
    logic [63:0] f, l;
    accept8(1'b0, 1'b0);
    collect8(1'b0, 1'b0, NB8, f, l);
    checks++;
    if (f !== 64'h0706050403020100) $display("FAIL basic_first got=%h exp=0706050403020100", f);
    else passes++;
    checks++;
    if (l !== 64'h00CECDCCCBCAC9C8) $display("FAIL basic_last got=%h exp=00cecdcccbcac9c8", l);
    else passes++;
    check_idle8("basic_drop", 1'b1);
  endtask

  task automatic test_stall();
    logic [63:0] f, l;
    accept8(1'b0, 1'b0);
    collect8(1'b0, 1'b1, NB8, f, l);
    checks++;
    if (l !== 64'h00CECDCCCBCAC9C8) $display("FAIL stall_last got=%h exp=00cecdcccbcac9c8", l);
    else passes++;
    check_idle8("stall_drop", 1'b1);
  endtask

  task automatic test_wide();
    logic [511:0] l;
    accept64(1'b0);
    collect64(1'b0, l);
    checks++;
    if (l !== 512'h00CECDCCCBCAC9C8C7C6C5C4C3C2C1C0) $display("FAIL wide_last got=%h exp=cecdcccbcac9c8c7c6c5c4c3c2c1c0", l);
    else passes++;
    @(negedge clk);
    checks++;
    if ({a64.val, hrdy64} !== 2'b01) $display("FAIL wide_drop got=%b exp=01", {a64.val, hrdy64});
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] f, l;
    accept8(1'b0, 1'b1);
    hdr = mk_hdr(1'b1);
    collect8(1'b0, 1'b0, NB8, f, l);
    check_idle8("b2b_bubble", 1'b1);
    @(posedge clk);
    #1 hv8 = 1'b0;
    collect8(1'b1, 1'b0, NB8, f, l);
    checks++;
    if (f !== 64'h342D261F18110A03) $display("FAIL b2b_second_first got=%h exp=342d261f18110a03", f);
    else passes++;
    check_idle8("b2b_drop", 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [63:0] f, l;
    logic [73:0] got;
    accept8(1'b0, 1'b0);
    collect8(1'b0, 1'b0, 50, f, l);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {a8.val, a8.sop, a8.eop, a8.mod, a8.dat, hrdy8, busy8};
    checks++;
    if (got !== '0) $display("FAIL rst_mid_async got=%h exp=0", got);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle8("rst_mid_release", 1'b1);
    accept8(1'b1, 1'b0);
    collect8(1'b1, 1'b0, NB8, f, l);
    checks++;
    if (f !== 64'h342D261F18110A03) $display("FAIL rst_mid_first got=%h exp=342d261f18110a03", f);
    else passes++;
    check_idle8("rst_mid_drop", 1'b1);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n = 1'b0;
    hv8 = 1'b0;
    hv64 = 1'b0;
    hdr = '0;
    a8.rdy = 1'b0;
    a64.rdy = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_wide();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
